frame_minmax_scanner: RTL

//  Upstream stage of data_normalizer. On i_start, reads one full frame of signed

---
 rtl/frame_minmax_scanner_if.sv | 28 ++
 rtl/frame_minmax_scanner.sv | 105 ++++++++++
 2 files changed

// File: rtl/frame_minmax_scanner_if.sv
// Bundles the scan request/result signals and the frame-buffer read port.
interface frame_minmax_scanner_if #(
  parameter int DATAW    = 16,
  parameter int MAX_ADDR = 768
);
  localparam int ADDRW = $clog2(MAX_ADDR);

  logic                    i_start;
  logic                    o_busy;
  logic                    o_rd_valid;
  logic [ADDRW-1:0]        o_rd_addr;
  logic signed [DATAW-1:0] i_rd_data;
  logic                    o_done;
  logic signed [DATAW-1:0] o_min;
  logic signed [DATAW-1:0] o_range;

  // Scanner side
  modport slave (
    input  i_start, i_rd_data,
    output o_busy, o_rd_valid, o_rd_addr, o_done, o_min, o_range
  );

  // Requester / frame-buffer side
  modport master (
    output i_start, i_rd_data,
    input  o_busy, o_rd_valid, o_rd_addr, o_done, o_min, o_range
  );
endinterface

// File: rtl/frame_minmax_scanner.sv
// Scans one frame of signed pixels, tracks min/max and publishes the frame
// minimum and a saturated, non-zero range with a one-cycle done pulse.
module frame_minmax_scanner #(
  parameter int DATAW    = 16,
  parameter int MAX_ADDR = 768,
  parameter int RD_LAT   = 1
) (
  input logic                    i_clk,
  input logic                    i_rst_n,
  frame_minmax_scanner_if.slave  bus
);
  localparam int ADDRW = $clog2(MAX_ADDR);
  localparam logic [RD_LAT-1:0] TAIL_ONLY = RD_LAT'(1) << (RD_LAT - 1);
  localparam logic [DATAW-1:0]  RANGE_MAX = {1'b0, {(DATAW-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t                  state, state_nxt;
  logic [RD_LAT-1:0]       vpipe;
  logic                    last_addr;
  logic                    sample;
  logic                    last_sample;
  logic                    first;
  logic signed [DATAW-1:0] cur_min, cur_max;
  logic [DATAW:0]          diff;
  logic [DATAW-1:0]        range_sat;

  assign last_addr   = (bus.o_rd_addr == ADDRW'(MAX_ADDR - 1));
  assign sample      = vpipe[RD_LAT-1];
  // Only the final in-flight sample remains once the read strobes have stopped.
  assign last_sample = (vpipe == TAIL_ONLY);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode and state-derived outputs
  always_comb begin
    state_nxt      = state;
    bus.o_busy     = (state != IDLE);
    bus.o_rd_valid = (state == READ);
    unique case (state)
      IDLE:    if (bus.i_start) state_nxt = READ;
      READ:    if (last_addr)   state_nxt = DRAIN;
      DRAIN:   if (last_sample) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read address: one per cycle while reading, parked at zero otherwise
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                      bus.o_rd_addr <= '0;
    else if (state == READ && !last_addr) bus.o_rd_addr <= bus.o_rd_addr + 1'b1;
    else                               bus.o_rd_addr <= '0;
  end

  // Return-path valid pipe tracking outstanding read strobes
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) vpipe <= '0;
    else          vpipe <= (vpipe << 1) | RD_LAT'(bus.o_rd_valid);
  end

  // Running min/max; first returned sample of a frame seeds both
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      first   <= 1'b0;
      cur_min <= '0;
      cur_max <= '0;
    end else if (state == IDLE && bus.i_start) begin
      first <= 1'b1;
    end else if (sample) begin
      first <= 1'b0;
      if (first || bus.i_rd_data < cur_min) cur_min <= bus.i_rd_data;
      if (first || bus.i_rd_data > cur_max) cur_max <= bus.i_rd_data;
    end
  end

  // Range in DATAW+1 bits, clamped to the positive maximum and forced non-zero
  assign diff = {cur_max[DATAW-1], cur_max} - {cur_min[DATAW-1], cur_min};

  // Range saturation and flat-frame substitution
  always_comb begin
    range_sat = diff[DATAW-1:0];
    if (diff[DATAW] || diff[DATAW-1]) range_sat = RANGE_MAX;
    else if (diff == '0)              range_sat = DATAW'(1);
  end

  // Published results, updated only alongside the done pulse
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.o_done  <= 1'b0;
      bus.o_min   <= '0;
      bus.o_range <= DATAW'(1);
    end else begin
      bus.o_done <= (state == DONE);
      if (state == DONE) begin
        bus.o_min   <= cur_min;
        bus.o_range <= range_sat;
      end
    end
  end
endmodule
